// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer.
// Holds the FSM state encoding, op codes and datapath widths.
package alu_seq_pkg;

    localparam int OPND_W = 2;
    localparam int RES_W  = 4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with occupancy count.
// Head entry is presented combinationally on dout.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // DEPTH is a power of two, so pointers wrap naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU requests and issues them one at a time to the multicycle ALU.
// Each result, or a forced timeout error, is returned with its tag.
module alu_cmd_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 8,
    parameter int TAG_W   = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [OPND_W-1:0]            cmd_a,
    input  logic [OPND_W-1:0]            cmd_b,
    input  logic [1:0]                   cmd_op,
    input  logic [TAG_W-1:0]             cmd_tag,
    output logic [OPND_W-1:0]            alu_a,
    output logic [OPND_W-1:0]            alu_b,
    output logic [1:0]                   alu_ctrl,
    output logic                         alu_start,
    input  logic [RES_W-1:0]             alu_y,
    input  logic                         alu_c,
    input  logic                         alu_done,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [RES_W-1:0]             rsp_y,
    output logic                         rsp_c,
    output logic [TAG_W-1:0]             rsp_tag,
    output logic                         rsp_timeout,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam int DW = 2 * OPND_W + 2 + TAG_W;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t          state;
    state_t          next;
    logic [TW-1:0]   timer;
    logic [TAG_W-1:0] iss_tag;
    logic [DW-1:0]   fifo_din;
    logic [DW-1:0]   fifo_dout;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            ld_done;
    logic            ld_tmo;

    // Ready comes from the registered count only: no pass-through at full
    assign cmd_ready = (count < CW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign fifo_din  = {cmd_a, cmd_b, cmd_op, cmd_tag};
    assign busy      = (state != IDLE) || !fifo_empty;

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .W     (DW),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next      = state;
        pop       = 1'b0;
        alu_start = 1'b0;
        rsp_valid = 1'b0;
        ld_done   = 1'b0;
        ld_tmo    = 1'b0;
        unique case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop  = 1'b1;
                    next = ISSUE;
                end
            end
            ISSUE: begin
                alu_start = 1'b1;
                next      = WAIT;
            end
            WAIT: begin
                if (alu_done) begin
                    ld_done = 1'b1;
                    next    = RESP;
                end else if (timer == TMO_LAST) begin
                    ld_tmo = 1'b1;
                    next   = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    if (!fifo_empty) begin
                        pop  = 1'b1;
                        next = ISSUE;
                    end else begin
                        next = IDLE;
                    end
                end
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_ctrl <= '0;
            iss_tag  <= '0;
        end else if (pop) begin
            {alu_a, alu_b, alu_ctrl, iss_tag} <= fifo_dout;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (state == ISSUE) begin
            timer <= '0;
        end else if (state == WAIT) begin
            timer <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_y       <= '0;
            rsp_c       <= 1'b0;
            rsp_tag     <= '0;
            rsp_timeout <= 1'b0;
        end else if (ld_done) begin
            rsp_y       <= alu_y;
            rsp_c       <= alu_c;
            rsp_tag     <= iss_tag;
            rsp_timeout <= 1'b0;
        end else if (ld_tmo) begin
            rsp_y       <= '0;
            rsp_c       <= 1'b1;
            rsp_tag     <= iss_tag;
            rsp_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a 2-cycle ALU model.
// The model can be disabled to provoke timeouts.
module tb_alu_cmd_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_a = '0;
    logic [1:0] cmd_b = '0;
    logic [1:0] cmd_op = '0;
    logic [1:0] cmd_tag = '0;
    logic [1:0] alu_a;
    logic [1:0] alu_b;
    logic [1:0] alu_ctrl;
    logic       alu_start;
    logic [3:0] alu_y = '0;
    logic       alu_c = 1'b0;
    logic       alu_done;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_y;
    logic       rsp_c;
    logic [1:0] rsp_tag;
    logic       rsp_timeout;
    logic       busy;
    logic [2:0] count;

    logic       alu_en = 1'b1;
    logic       model_done = 1'b0;
    logic       manual_done = 1'b0;
    int         dly = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    assign alu_done = model_done | manual_done;

    always #5 clk = ~clk;

    alu_cmd_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_op      (cmd_op),
        .cmd_tag     (cmd_tag),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_start   (alu_start),
        .alu_y       (alu_y),
        .alu_c       (alu_c),
        .alu_done    (alu_done),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_y       (rsp_y),
        .rsp_c       (rsp_c),
        .rsp_tag     (rsp_tag),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .count       (count)
    );

    // ALU model: done two cycles after the start pulse
    always @(negedge clk) begin
        model_done = 1'b0;
        if (alu_en && alu_start) begin
            dly = 2;
        end else if (dly != 0) begin
            dly = dly - 1;
            if (dly == 0) begin
                model_done = 1'b1;
                alu_c = 1'b0;
                case (alu_ctrl)
                    2'b00: alu_y = {2'b00, alu_a} + {2'b00, alu_b};
                    2'b01: alu_y = {2'b00, alu_a} - {2'b00, alu_b};
                    2'b10: alu_y = {2'b00, alu_a} * {2'b00, alu_b};
                    default: begin
                        if (alu_b == 2'd0) begin
                            alu_y = 4'd0;
                            alu_c = 1'b1;
                        end else begin
                            alu_y = {2'b00, alu_a / alu_b};
                        end
                    end
                endcase
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_cmd(input logic [1:0] a, input logic [1:0] b,
                             input logic [1:0] op, input logic [1:0] tag);
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_tag   = tag;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name, output int cycles);
        cycles = 0;
        while (!rsp_valid && cycles < 40) begin
            step();
            cycles++;
        end
        if (!rsp_valid) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: rsp_valid timeout got 0 expected 1", name);
        end
    endtask

    task automatic test_reset();
        repeat (2) step();
        n_checks++;
        if (cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_cmd_ready: got %0b expected 1", cmd_ready);
        end
        n_checks++;
        if ({rsp_valid, alu_start, busy, count} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {rsp_valid, alu_start, busy, count});
        end
        n_checks++;
        if ({alu_a, alu_b, alu_ctrl, rsp_y, rsp_c, rsp_tag, rsp_timeout} !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 0",
                     {alu_a, alu_b, alu_ctrl, rsp_y, rsp_c, rsp_tag, rsp_timeout});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_single();
        int cyc;
        alu_en    = 1'b1;
        rsp_ready = 1'b0;
        drive_cmd(2'd3, 2'd2, 2'b00, 2'd1);
        chk("single_start_early", int'(alu_start), 0);
        step();
        chk("single_start", int'(alu_start), 1);
        chk("single_alu_ops", int'({alu_a, alu_b, alu_ctrl}), 6'b11_10_00);
        wait_rsp("single", cyc);
        chk("single_rsp_latency", cyc, 3);
        chk("single_rsp_y", int'(rsp_y), 5);
        chk("single_rsp_c", int'(rsp_c), 0);
        chk("single_rsp_tag", int'(rsp_tag), 1);
        chk("single_rsp_timeout", int'(rsp_timeout), 0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        chk("single_after_hs_valid", int'(rsp_valid), 0);
        chk("single_after_hs_busy", int'(busy), 0);
    endtask

    task automatic test_back_to_back();
        logic [1:0] va [5] = '{2'd1, 2'd3, 2'd3, 2'd3, 2'd2};
        logic [1:0] vb [5] = '{2'd1, 2'd1, 2'd3, 2'd2, 2'd3};
        logic [1:0] vo [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00};
        logic [1:0] vt [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        int         ey [5] = '{2, 2, 9, 1, 5};
        int         got = 0;
        alu_en    = 1'b1;
        rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_cmd(va[i], vb[i], vo[i], vt[i]);
        end
        chk("b2b_count_full", int'(count), 4);
        chk("b2b_ready_full", int'(cmd_ready), 0);
        drive_cmd(2'd1, 2'd1, 2'b00, 2'd2);
        chk("b2b_push_refused", int'(count), 4);
        rsp_ready = 1'b1;
        for (int c = 0; c < 60 && got < 5; c++) begin
            if (rsp_valid) begin
                chk($sformatf("b2b_tag%0d", got), int'(rsp_tag), int'(vt[got]));
                chk($sformatf("b2b_y%0d", got), int'(rsp_y), ey[got]);
                got++;
            end
            step();
        end
        rsp_ready = 1'b0;
        chk("b2b_rsp_count", got, 5);
        chk("b2b_idle", int'(busy), 0);
    endtask

    task automatic test_timeout();
        int cyc = 0;
        alu_en    = 1'b0;
        rsp_ready = 1'b0;
        drive_cmd(2'd2, 2'd0, 2'b11, 2'd2);
        while (!alu_start && cyc < 10) begin
            step();
            cyc++;
        end
        chk("tmo_start_seen", int'(alu_start), 1);
        cyc = 0;
        while (!rsp_valid && cyc < 30) begin
            step();
            cyc++;
        end
        chk("tmo_latency", cyc, 9);
        chk("tmo_rsp_y", int'(rsp_y), 0);
        chk("tmo_rsp_c", int'(rsp_c), 1);
        chk("tmo_rsp_timeout", int'(rsp_timeout), 1);
        chk("tmo_rsp_tag", int'(rsp_tag), 2);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        alu_en    = 1'b1;
    endtask

    task automatic test_hold();
        int cyc;
        int got = 0;
        int et [3] = '{1, 2, 3};
        int ey [3] = '{3, 4, 2};
        alu_en    = 1'b1;
        rsp_ready = 1'b0;
        drive_cmd(2'd1, 2'd2, 2'b00, 2'd1);
        drive_cmd(2'd2, 2'd2, 2'b10, 2'd2);
        drive_cmd(2'd3, 2'd1, 2'b01, 2'd3);
        wait_rsp("hold", cyc);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", int'(rsp_valid), 1);
            chk("hold_rsp", int'({rsp_y, rsp_c, rsp_tag, rsp_timeout}), 8'b0011_0_01_0);
            chk("hold_start", int'(alu_start), 0);
            chk("hold_alu_ops", int'({alu_a, alu_b, alu_ctrl}), 6'b01_10_00);
            chk("hold_count", int'(count), 2);
            step();
        end
        rsp_ready = 1'b1;
        for (int c = 0; c < 40 && got < 3; c++) begin
            if (rsp_valid) begin
                chk($sformatf("hold_tag%0d", got), int'(rsp_tag), et[got]);
                chk($sformatf("hold_y%0d", got), int'(rsp_y), ey[got]);
                got++;
            end
            step();
        end
        rsp_ready = 1'b0;
        chk("hold_rsp_count", got, 3);
    endtask

    task automatic test_reset_mid();
        alu_en    = 1'b0;
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_cmd(2'(i), 2'd1, 2'b00, 2'(i));
        end
        step();
        chk("rmid_count_pre", int'(count), 3);
        chk("rmid_busy_pre", int'(busy), 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rmid_count", int'(count), 0);
        chk("rmid_busy", int'(busy), 0);
        chk("rmid_valid", int'(rsp_valid), 0);
        chk("rmid_ready", int'(cmd_ready), 1);
        chk("rmid_alu_ops", int'({alu_a, alu_b, alu_ctrl}), 0);
        @(negedge clk);
        manual_done = 1'b1;
        @(negedge clk);
        manual_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("rmid_no_rsp", int'(rsp_valid), 0);
        end
        chk("rmid_idle", int'(busy), 0);
        alu_en = 1'b1;
    endtask

    task automatic test_idle_done();
        @(negedge clk);
        manual_done = 1'b1;
        @(negedge clk);
        manual_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("idle_done_valid", int'(rsp_valid), 0);
            chk("idle_done_busy", int'(busy), 0);
            chk("idle_done_start", int'(alu_start), 0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_hold();
        test_reset_mid();
        test_idle_done();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
